// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word bit positions, default datapath sizes,
// and the program-counter command decode used by the PC block.
package cpu_pkg;

  localparam int CS_CP   = 14;
  localparam int CS_EP   = 13;
  localparam int CS_LP   = 12;
  localparam int CS_CALL = 11;
  localparam int CS_RET  = 10;

  localparam int DEFAULT_ADDR_W      = 4;
  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CP,
    CMD_LP,
    CMD_RET,
    CMD_CALL
  } pc_cmd_e;

  // Only the highest-priority command is acted on: call > ret > lp > cp.
  function automatic pc_cmd_e decode_cmd(input logic call, input logic ret,
                                         input logic lp, input logic cp);
    if (call)     return CMD_CALL;
    else if (ret) return CMD_RET;
    else if (lp)  return CMD_LP;
    else if (cp)  return CMD_CP;
    else          return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO. Only the occupancy count is reset; entry contents are
// don't-care until written.
module pc_return_stack #(
  parameter int W = 4,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [0:(2**AW)-1];
  logic [DW-1:0] cnt;

  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign dout  = mem[AW'(cnt - DW'(1))];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(cnt)] <= din;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with count/load/bus-enable control and a hardware
// return-address stack for call/ret, with sticky overflow/underflow flags.
module program_counter_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cp,
  input  logic               lp,
  input  logic               ep,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  bits_in,
  output logic [ADDR_W-1:0]  bits_out,
  output logic               bus_oe,
  output logic [ADDR_W-1:0]  pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               err_ovf,
  output logic               err_unf
);

  pc_cmd_e           cmd;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] top;
  logic              push;
  logic              pop;

  always_comb begin
    cmd  = decode_cmd(call, ret, lp, cp);
    push = (cmd == CMD_CALL) && !stack_full;
    pop  = (cmd == CMD_RET) && !stack_empty;
  end

  pc_return_stack #(
    .W(ADDR_W),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(pc_q),
    .dout(top),
    .depth(depth),
    .full(stack_full),
    .empty(stack_empty)
  );

  // A rejected call/ret leaves the PC alone and only raises its sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      case (cmd)
        CMD_CALL: if (stack_full) err_ovf <= 1'b1; else pc_q <= bits_in;
        CMD_RET:  if (stack_empty) err_unf <= 1'b1; else pc_q <= top;
        CMD_LP:   pc_q <= bits_in;
        CMD_CP:   pc_q <= pc_q + ADDR_W'(1);
        default:  ;
      endcase
    end
  end

  assign pc       = pc_q;
  assign bus_oe   = ep;
  assign bits_out = ep ? pc_q : '0;

endmodule

// File: tb/tb_program_counter_stack.sv
// Drives two configurations (4-bit/4-deep/vec 0 and 8-bit/1-deep/vec 80h) with
// the same command stream and checks both against a behavioural stack model.
module tb_program_counter_stack;

  logic       clk = 1'b0;
  logic       rst_n, cp, lp, ep, call, ret;
  logic [7:0] bits_in;

  logic [3:0] bits_out_a, pc_a;
  logic [2:0] depth_a;
  logic       bus_oe_a, full_a, empty_a, eo_a, eu_a;
  logic [7:0] bits_out_b, pc_b;
  logic [0:0] depth_b;
  logic       bus_oe_b, full_b, empty_b, eo_b, eu_b;

  int n_cmp = 0;
  int n_err = 0;

  int aw [2] = '{4, 8};
  int sd [2] = '{4, 1};
  int rv [2] = '{0, 128};
  int pc_m [2];
  int cnt_m [2];
  int stk [2][16];
  bit eo_m [2];
  bit eu_m [2];

  always #5 clk = ~clk;

  program_counter_stack #(.ADDR_W(4), .STACK_DEPTH(4), .RESET_VEC(4'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cp(cp), .lp(lp), .ep(ep), .call(call), .ret(ret),
    .bits_in(bits_in[3:0]), .bits_out(bits_out_a), .bus_oe(bus_oe_a), .pc(pc_a),
    .depth(depth_a), .stack_full(full_a), .stack_empty(empty_a),
    .err_ovf(eo_a), .err_unf(eu_a)
  );

  program_counter_stack #(.ADDR_W(8), .STACK_DEPTH(1), .RESET_VEC(8'h80)) dut_b (
    .clk(clk), .rst_n(rst_n), .cp(cp), .lp(lp), .ep(ep), .call(call), .ret(ret),
    .bits_in(bits_in), .bits_out(bits_out_b), .bus_oe(bus_oe_b), .pc(pc_b),
    .depth(depth_b), .stack_full(full_b), .stack_empty(empty_b),
    .err_ovf(eo_b), .err_unf(eu_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit c, input bit r, input bit l, input bit p,
                              input logic [7:0] b, input bit rn);
    for (int k = 0; k < 2; k++) begin
      int modv;
      modv = 1 << aw[k];
      if (!rn) begin
        pc_m[k] = rv[k]; cnt_m[k] = 0; eo_m[k] = 0; eu_m[k] = 0;
      end else if (c) begin
        if (cnt_m[k] == sd[k]) eo_m[k] = 1;
        else begin
          stk[k][cnt_m[k]] = pc_m[k];
          cnt_m[k]++;
          pc_m[k] = int'(b) % modv;
        end
      end else if (r) begin
        if (cnt_m[k] == 0) eu_m[k] = 1;
        else begin
          cnt_m[k]--;
          pc_m[k] = stk[k][cnt_m[k]];
        end
      end else if (l) begin
        pc_m[k] = int'(b) % modv;
      end else if (p) begin
        pc_m[k] = (pc_m[k] + 1) % modv;
      end
    end
  endtask

  task automatic check_comb();
    chk("a_bits_out", 32'(bits_out_a), ep ? pc_m[0] : 0);
    chk("a_bus_oe", 32'(bus_oe_a), 32'(ep));
    chk("b_bits_out", 32'(bits_out_b), ep ? pc_m[1] : 0);
    chk("b_bus_oe", 32'(bus_oe_b), 32'(ep));
  endtask

  task automatic check_state();
    chk("a_pc", 32'(pc_a), pc_m[0]);
    chk("a_depth", 32'(depth_a), cnt_m[0]);
    chk("a_full", 32'(full_a), 32'(cnt_m[0] == sd[0]));
    chk("a_empty", 32'(empty_a), 32'(cnt_m[0] == 0));
    chk("a_err_ovf", 32'(eo_a), 32'(eo_m[0]));
    chk("a_err_unf", 32'(eu_a), 32'(eu_m[0]));
    chk("b_pc", 32'(pc_b), pc_m[1]);
    chk("b_depth", 32'(depth_b), cnt_m[1]);
    chk("b_full", 32'(full_b), 32'(cnt_m[1] == sd[1]));
    chk("b_empty", 32'(empty_b), 32'(cnt_m[1] == 0));
    chk("b_err_ovf", 32'(eo_b), 32'(eo_m[1]));
    chk("b_err_unf", 32'(eu_b), 32'(eu_m[1]));
  endtask

  // One clock: apply inputs, check the bus outputs before the edge, then the state after it.
  task automatic step(input bit c, input bit r, input bit l, input bit p, input bit e,
                      input logic [7:0] b, input bit rn);
    call = c; ret = r; lp = l; cp = p; ep = e; bits_in = b; rst_n = rn;
    #2;
    check_comb();
    @(posedge clk);
    model_update(c, r, l, p, b, rn);
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; cp = 1'b0; lp = 1'b0; ep = 1'b0; call = 1'b0; ret = 1'b0; bits_in = '0;
    for (int k = 0; k < 2; k++) begin
      pc_m[k] = rv[k]; cnt_m[k] = 0; eo_m[k] = 0; eu_m[k] = 0;
    end
    @(posedge clk);
    #1;

    // Reset, then count through the 4-bit wrap.
    step(0, 0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, 8'h00, 1);

    // Load, then enable together with count: pre-increment value on the bus.
    step(0, 0, 1, 0, 0, 8'h0A, 1);
    step(0, 0, 0, 1, 1, 8'h00, 1);

    // Nested call / return.
    step(0, 0, 1, 0, 0, 8'h03, 1);
    step(1, 0, 0, 0, 0, 8'h08, 1);
    step(1, 0, 0, 0, 1, 8'h0C, 1);
    step(0, 1, 0, 0, 0, 8'h00, 1);
    step(0, 1, 0, 0, 1, 8'h00, 1);

    // Overflow, then LIFO restore.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 8'h05, 1);
    step(1, 0, 0, 0, 0, 8'h07, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 8'h00, 1);

    // Underflow, then all commands at once: call wins; a ret exposes the pushed 6.
    step(0, 0, 1, 0, 0, 8'h06, 1);
    step(0, 1, 0, 0, 0, 8'h00, 1);
    step(1, 1, 1, 1, 0, 8'h02, 1);
    step(0, 1, 0, 0, 1, 8'h00, 1);

    // Reset in the middle of a call sequence.
    step(1, 0, 0, 0, 0, 8'h09, 1);
    step(1, 0, 0, 0, 0, 8'h0B, 1);
    step(1, 1, 0, 0, 0, 8'h0D, 0);
    step(0, 0, 0, 0, 1, 8'h00, 1);

    // Wrap from all-ones for both widths.
    step(0, 0, 1, 0, 0, 8'hFF, 1);
    step(0, 0, 0, 1, 1, 8'h00, 1);
    step(0, 0, 0, 1, 1, 8'h00, 1);

    // Random command mix with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 40) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the CPU program counter.
- Keeps the count/load/enable control set (cp, lp, ep) and adds configurable address width, a configurable-depth hardware return-address stack (call/ret), wrap-around, and sticky stack error flags.
- Sits on the CPU bus between the control block and memory address logic.
- Drives the bus only through an explicit output-enable pair; there is no internal tri-state.

Parameters:
- ADDR_W, 4: program counter and bus address width in bits (legal range 2..16).
- STACK_DEPTH, 4: number of return-address entries (legal range 1..16).
- RESET_VEC, 0: value loaded into the PC on reset; must fit in ADDR_W bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- cp  in  1  count enable: PC <= PC+1.
- lp  in  1  load PC from bits_in.
- ep  in  1  enable PC onto the bus.
- call  in  1  push PC, then load PC from bits_in.
- ret  in  1  pop top of stack into PC.
- bits_in  in  ADDR_W  bus value used by lp and call.
- bits_out  out  ADDR_W  equals PC when ep=1, else all zeros.
- bus_oe  out  1  equals ep; the top level uses it to gate the bus driver.
- pc  out  ADDR_W  current PC, always visible for debug.
- depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- err_ovf  out  1  sticky: a call was attempted while the stack was full.
- err_unf  out  1  sticky: a ret was attempted while the stack was empty.

Behaviour:
- Reset (rst_n=0 at a clk edge): PC=RESET_VEC, depth=0, err_ovf=0, err_unf=0. Stack storage contents are don't-care.
  - While rst_n is low, the combinational outputs still follow their definitions: pc=RESET_VEC after the first edge, stack_empty=1, stack_full=0.
  - Reset overrides every other input on the same edge, so reset in the middle of a call/ret sequence abandons it cleanly.
- Output timing: bits_out and bus_oe are combinational from ep and the registered PC; no added latency. All other outputs are registered or decoded from registered state.
- Priority when several commands are high on one edge: call > ret > lp > cp. Only the highest-priority command takes effect; the others are ignored entirely, with no partial effect.
- call, stack not full: stack[depth] <= PC (the caller has already incremented PC during fetch); depth <= depth+1; PC <= bits_in.
- call, stack full: PC unchanged, depth unchanged, err_ovf <= 1.
- ret, stack not empty: PC <= stack[depth-1]; depth <= depth-1.
- ret, stack empty: PC unchanged, err_unf <= 1.
- lp: PC <= bits_in; stack unchanged.
- cp: PC <= PC+1 modulo 2^ADDR_W, so all-ones wraps to 0 with no flag.
- No command: all state holds.
- Error flags are sticky and are cleared only by reset. A set flag does not block later legal operations.
- ep is independent of the command inputs. With ep=1 and cp=1 on the same cycle, the pre-increment PC appears on bits_out.
- Command inputs are level-sampled once per edge. Holding call high for N cycles performs N pushes.
- Width rule: all PC arithmetic is ADDR_W bits, and the carry is discarded.

Decomposition:
- Shared package cpu_pkg holds the control-word bit index constants: CS_CP=14, CS_EP=13, CS_LP=12, plus new CS_CALL=11 and CS_RET=10. It also holds the default ADDR_W and STACK_DEPTH localparams so the control block and this block agree.
- One sub-module, pc_return_stack, implements the LIFO:
  - parameters W and DEPTH;
  - inputs push, pop, din;
  - outputs dout (top entry), depth, full, empty;
  - synchronous active-low reset of depth only.
- program_counter_stack contains the PC register, the priority decode, the error flags and the bus gating.

Test Plan:
- Reset then count, ADDR_W=4, RESET_VEC=0: hold rst_n=0 for 2 cycles, then cp=1 for 17 cycles -> pc steps 0,1,...,15,0,1; stack_empty=1 throughout; bits_out=0 while ep=0.
- Load and enable: lp=1 with bits_in=4'hA -> pc=A on the next edge; then ep=1 with cp=1 -> bits_out=A that cycle, pc=B after the edge, bus_oe=1.
- Nested call/return, STACK_DEPTH=4: from pc=3, call to 8; at pc=8, call to C; then ret, ret -> pc sequence 8, C, 8, 3; depth 1, 2, 1, 0.
- Overflow: four calls, each with target 5 -> stack_full=1; a fifth call with bits_in=7 -> pc stays 5, depth=4, err_ovf=1. Four rets then restore the pushed values in LIFO order and err_ovf stays 1.
- Underflow and priority: ret with the stack empty at pc=6 -> pc=6, err_unf=1. Then call, ret, lp and cp all high with bits_in=2 from pc=6 -> call wins: pc=2, depth=1, stack top=6.
- Reset mid-operation plus a parameter sweep: pulse rst_n=0 after two pushes -> depth=0, both error flags 0, pc=RESET_VEC. Repeat the whole suite with ADDR_W=8, STACK_DEPTH=1, RESET_VEC=8'h80, checking that cp wraps FF -> 00.
